regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (regWrite / writeRegister / writeData) between two writeback requesters.
  - Requester 0: ALU writeback.
  - Requester 1: memory-load writeback.
- Each requester has a 1-entry holding buffer with a valid/ready handshake.
- Buffered writes are committed oldest-first through a registered write port.
- A pending-write scoreboard is exported for hazard detection in the decode stage.

---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channels, register-file write port and pending scoreboard
// shared between the requesters (master) and the write arbiter (slave).
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  localparam int NREG = 2 ** REG_AW;

  logic              req0_valid;
  logic              req0_ready;
  logic [REG_AW-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [REG_AW-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;

  logic              regWrite;
  logic [REG_AW-1:0] writeRegister;
  logic [DATA_W-1:0] writeData;
  logic [NREG-1:0]   pending;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  regWrite, writeRegister, writeData, pending
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output regWrite, writeRegister, writeData, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: one holding buffer per requester,
// oldest-first commit through a registered write port, pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input logic                   clock,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;

  logic              full0_q, full0_d;
  logic [REG_AW-1:0] reg0_q, reg0_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic              full1_q, full1_d;
  logic [REG_AW-1:0] reg1_q, reg1_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              older1_q, older1_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic grant0, grant1, ready0, ready1, acc0, acc1;
  logic [NREG-1:0] pending_w;

  // Grants look only at buffer state, so ready never depends on valid.
  assign grant0 = full0_q & (~full1_q | ~older1_q);
  assign grant1 = full1_q & (~full0_q | older1_q);
  assign ready0 = ~full0_q | grant0;
  assign ready1 = ~full1_q | grant1;
  assign acc0   = bus.req0_valid & ready0;
  assign acc1   = bus.req1_valid & ready1;

  always_comb begin
    full0_d  = full0_q;
    reg0_d   = reg0_q;
    data0_d  = data0_q;
    full1_d  = full1_q;
    reg1_d   = reg1_q;
    data1_d  = data1_q;
    older1_d = older1_q;
    we_d     = grant0 | grant1;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;

    if (grant0) begin
      full0_d = 1'b0;
      wreg_d  = reg0_q;
      wdata_d = data0_q;
    end
    if (grant1) begin
      full1_d = 1'b0;
      wreg_d  = reg1_q;
      wdata_d = data1_q;
    end

    // A refill in the same edge as the grant keeps the buffer full.
    if (acc0) begin
      full0_d = 1'b1;
      reg0_d  = bus.req0_reg;
      data0_d = bus.req0_data;
    end
    if (acc1) begin
      full1_d = 1'b1;
      reg1_d  = bus.req1_reg;
      data1_d = bus.req1_data;
    end

    if (acc0 && acc1) begin
      older1_d = 1'b0;
    end else if (acc1) begin
      older1_d = ~full0_q | grant0;
    end else if (acc0) begin
      older1_d = full1_q & ~grant1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full0_q  <= 1'b0;
      reg0_q   <= '0;
      data0_q  <= '0;
      full1_q  <= 1'b0;
      reg1_q   <= '0;
      data1_q  <= '0;
      older1_q <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      full0_q  <= full0_d;
      reg0_q   <= reg0_d;
      data0_q  <= data0_d;
      full1_q  <= full1_d;
      reg1_q   <= reg1_d;
      data1_q  <= data1_d;
      older1_q <= older1_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Scoreboard: a register is pending while buffered or in the output stage.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    assign pending_w[gi] = (full0_q && (reg0_q == REG_AW'(gi))) ||
                           (full1_q && (reg1_q == REG_AW'(gi))) ||
                           (we_q    && (wreg_q == REG_AW'(gi)));
  end

  assign bus.req0_ready    = ready0;
  assign bus.req1_ready    = ready1;
  assign bus.regWrite      = we_q;
  assign bus.writeRegister = wreg_q;
  assign bus.writeData     = wdata_q;
  assign bus.pending       = pending_w;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, reset corner case and
// random traffic checked against an acceptance-ordered queue model.
module tb_regfile_write_arbiter;
  logic clock;
  logic reset;

  regfile_write_arbiter_if #(.DATA_W(16), .REG_AW(3)) bus ();

  regfile_write_arbiter #(.DATA_W(16), .REG_AW(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: writes held in buffers, kept in acceptance order (req0 first on a tie).
  typedef struct {
    bit        src;
    bit [2:0]  r;
    bit [15:0] d;
  } ent_t;
  ent_t     mq[$];
  bit       m_we;
  bit [2:0] m_wreg;
  bit [15:0] m_wdata;

  logic s_rdy0, s_rdy1;

  typedef struct {
    bit        v0;
    bit [2:0]  r0;
    bit [15:0] d0;
    bit        v1;
    bit [2:0]  r1;
    bit [15:0] d1;
    bit        e_rdy0;
    bit        e_rdy1;
    bit        e_we;
    bit [2:0]  e_wreg;
    bit [15:0] e_wdata;
    bit [7:0]  e_pend;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit src);
    bit has = 0;
    foreach (mq[k]) if (mq[k].src == src) has = 1;
    return !has || (mq.size() > 0 && mq[0].src == src);
  endfunction

  function automatic bit [7:0] model_pending();
    bit [7:0] p = '0;
    foreach (mq[k]) p[mq[k].r] = 1'b1;
    if (m_we) p[m_wreg] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we    = 0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  // One clock cycle: drive after negedge, check ready, take edge, check outputs.
  task automatic step(input bit v0, input bit [2:0] r0, input bit [15:0] d0,
                      input bit v1, input bit [2:0] r1, input bit [15:0] d1);
    bit   a0, a1;
    ent_t e;
    @(negedge clock);
    bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_data = d1;
    #1;
    s_rdy0 = bus.req0_ready;
    s_rdy1 = bus.req1_ready;
    chk("ready0", s_rdy0, model_ready(0));
    chk("ready1", s_rdy1, model_ready(1));
    a0 = v0 && model_ready(0);
    a1 = v1 && model_ready(1);
    @(posedge clock);
    if (mq.size() > 0) begin
      m_we    = 1;
      m_wreg  = mq[0].r;
      m_wdata = mq[0].d;
      void'(mq.pop_front());
    end else begin
      m_we = 0;
    end
    if (a0) begin e.src = 0; e.r = r0; e.d = d0; mq.push_back(e); end
    if (a1) begin e.src = 1; e.r = r1; e.d = d1; mq.push_back(e); end
    #1;
    chk("regWrite", bus.regWrite, m_we);
    chk("writeRegister", bus.writeRegister, m_wreg);
    chk("writeData", bus.writeData, m_wdata);
    chk("pending", bus.pending, model_pending());
  endtask

  function automatic vec_t mk(input bit v0, input bit [2:0] r0, input bit [15:0] d0,
                              input bit v1, input bit [2:0] r1, input bit [15:0] d1,
                              input bit rd0, input bit rd1, input bit we,
                              input bit [2:0] wr, input bit [15:0] wd, input bit [7:0] pd);
    vec_t v;
    v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.e_rdy0 = rd0; v.e_rdy1 = rd1; v.e_we = we; v.e_wreg = wr; v.e_wdata = wd;
    v.e_pend = pd;
    return v;
  endfunction

  initial begin
    bus.req0_valid = 0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_reg = '0; bus.req1_data = '0;
    s_rdy0 = 0; s_rdy1 = 0;
    model_reset();

    // Single write r3, latency and scoreboard lifetime
    vecs.push_back(mk(1,3,16'h1234, 0,0,0,     1,1, 0,0,16'h0000,    8'h08));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 1,3,16'h1234,    8'h08));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 0,3,16'h1234,    8'h00));
    // Same-cycle tie: req0 commits first
    vecs.push_back(mk(1,1,16'h00AA, 1,2,16'h00BB, 1,1, 0,3,16'h1234, 8'h06));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,0, 1,1,16'h00AA,    8'h06));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 1,2,16'h00BB,    8'h04));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 0,2,16'h00BB,    8'h00));
    // Both write r5 in one cycle: req1 value is final
    vecs.push_back(mk(1,5,16'h1111, 1,5,16'h2222, 1,1, 0,2,16'h00BB, 8'h20));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,0, 1,5,16'h1111,    8'h20));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 1,5,16'h2222,    8'h20));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 0,5,16'h2222,    8'h00));
    // req1 alone, then both: older req1 entry first, then req0, then new req1
    vecs.push_back(mk(0,0,0,        1,6,16'h0606, 1,1, 0,5,16'h2222, 8'h40));
    vecs.push_back(mk(1,4,16'h0404, 1,7,16'h0707, 1,1, 1,6,16'h0606, 8'hD0));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,0, 1,4,16'h0404,    8'h90));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 1,7,16'h0707,    8'h80));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 0,7,16'h0707,    8'h00));
    // req0 streams r0..r7 back-to-back
    for (int r = 0; r < 8; r++) begin
      vecs.push_back(mk(1, 3'(r), 16'(16'h100 + r), 0,0,0, 1,1,
                        (r > 0),
                        (r > 0) ? 3'(r - 1) : 3'd7,
                        (r > 0) ? 16'(16'h100 + r - 1) : 16'h0707,
                        8'(8'd1 << r) | ((r > 0) ? 8'(8'd1 << (r - 1)) : 8'h00)));
    end
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 1,7,16'h0107,    8'h80));
    vecs.push_back(mk(0,0,0,        0,0,0,     1,1, 0,7,16'h0107,    8'h00));

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_regWrite", bus.regWrite, 1'b0);
    chk("rst_writeRegister", bus.writeRegister, 3'd0);
    chk("rst_writeData", bus.writeData, 16'h0);
    chk("rst_pending", bus.pending, 8'h00);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v0, vecs[i].r0, vecs[i].d0, vecs[i].v1, vecs[i].r1, vecs[i].d1);
      chk($sformatf("vec%0d_ready0", i), s_rdy0, vecs[i].e_rdy0);
      chk($sformatf("vec%0d_ready1", i), s_rdy1, vecs[i].e_rdy1);
      chk($sformatf("vec%0d_regWrite", i), bus.regWrite, vecs[i].e_we);
      chk($sformatf("vec%0d_writeRegister", i), bus.writeRegister, vecs[i].e_wreg);
      chk($sformatf("vec%0d_writeData", i), bus.writeData, vecs[i].e_wdata);
      chk($sformatf("vec%0d_pending", i), bus.pending, vecs[i].e_pend);
    end

    // Reset while both buffers are full and a write is in flight
    step(1, 1, 16'hAAAA, 1, 2, 16'hBBBB);
    step(1, 3, 16'hCCCC, 0, 0, 0);
    chk("pre_rst_regWrite", bus.regWrite, 1'b1);
    chk("pre_rst_pending", bus.pending, 8'h0E);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_regWrite", bus.regWrite, 1'b0);
    chk("async_rst_pending", bus.pending, 8'h00);
    chk("async_rst_writeData", bus.writeData, 16'h0);
    model_reset();
    @(negedge clock);
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_no_stale", bus.regWrite, 1'b0);
    end

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom),
           $urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    chk("drained_pending", bus.pending, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
